// File: rtl/cpu_pkg.sv
// Shared types and constants for the integer-core pipeline control logic.
package cpu_pkg;

  localparam int unsigned HZ_RD_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               wr;
    logic               late;
  } hz_slot_t;

  // x0 is hard-wired zero, so a slot targeting it never produces a hazard.
  function automatic logic slot_hit(input hz_slot_t s, input logic [HZ_RD_W-1:0] rs);
    return s.valid && s.wr && (s.rd != '0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_mul_timer.sv
// Multi-cycle multiply countdown; busy while extra EX cycles remain.
module hazard_mul_timer #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic busy
);

  localparam int unsigned CW = 4;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end else if (load) begin
      count <= CW'(MUL_LATENCY - 1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock: stall/bubble/flush and forwarding selects for the 5-stage core.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_hazard_0,
  input  logic                  id_is_multiply,
  input  logic                  ex_taken,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [1:0]            fwd_rs1,
  output logic [1:0]            fwd_rs2,
  output logic                  mul_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  hz_slot_t           ex_slot, mem_slot, id_slot;
  logic [HZ_RD_W-1:0] rs1, rs2;
  logic               ex_hit1, ex_hit2, mem_hit1, mem_hit2, late_hit;
  logic               busy, active, mul_load;
  logic               stall_i, bubble_i, flush_i;
  logic [1:0]         fwd1_i, fwd2_i;

  assign rs1 = HZ_RD_W'(id_rs1);
  assign rs2 = HZ_RD_W'(id_rs2);

  assign ex_hit1  = id_valid && id_use_rs1 && slot_hit(ex_slot, rs1);
  assign ex_hit2  = id_valid && id_use_rs2 && slot_hit(ex_slot, rs2);
  assign mem_hit1 = id_valid && id_use_rs1 && slot_hit(mem_slot, rs1);
  assign mem_hit2 = id_valid && id_use_rs2 && slot_hit(mem_slot, rs2);
  assign late_hit = (ex_hit1 || ex_hit2) && ex_slot.late;

  always_comb begin
    stall_i  = 1'b0;
    bubble_i = 1'b0;
    flush_i  = 1'b0;
    if (busy) begin
      stall_i = 1'b1;
    end else if (ex_taken) begin
      flush_i  = 1'b1;
      bubble_i = 1'b1;
    end else if (late_hit) begin
      stall_i  = 1'b1;
      bubble_i = 1'b1;
    end
  end

  // A late EX match shadows MEM: the MEM value is older than the pending result.
  always_comb begin
    fwd1_i = FWD_REGFILE;
    fwd2_i = FWD_REGFILE;
    if (ex_hit1)       fwd1_i = ex_slot.late ? FWD_REGFILE : FWD_EX;
    else if (mem_hit1) fwd1_i = FWD_MEM;
    if (ex_hit2)       fwd2_i = ex_slot.late ? FWD_REGFILE : FWD_EX;
    else if (mem_hit2) fwd2_i = FWD_MEM;
  end

  always_comb begin
    id_slot       = '0;
    id_slot.valid = id_valid && !bubble_i;
    id_slot.rd    = HZ_RD_W'(id_rd);
    id_slot.wr    = id_reg_write;
    id_slot.late  = id_is_hazard_0;
    if (!id_slot.valid) id_slot = '0;
  end

  assign mul_load = !busy && id_valid && id_is_multiply && !bubble_i;

  hazard_mul_timer #(.MUL_LATENCY(MUL_LATENCY)) u_mul_timer (
    .clk  (clk),
    .rstn (rstn),
    .load (mul_load),
    .busy (busy)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      active   <= 1'b0;
    end else begin
      active <= 1'b1;
      if (!busy) begin
        mem_slot <= ex_slot;
        ex_slot  <= id_slot;
      end
    end
  end

  // Outputs stay quiet from reset until the first edge after release.
  assign stall    = active && stall_i;
  assign bubble   = active && bubble_i;
  assign flush    = active && flush_i;
  assign fwd_rs1  = active ? fwd1_i : FWD_REGFILE;
  assign fwd_rs2  = active ? fwd2_i : FWD_REGFILE;
  assign mul_busy = active && busy;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (flush) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule
